// File: rtl/fmap_pingpong_if.sv
// Writer, reader and dual-port RAM signals of the feature-map ping-pong buffer.
// slave: the controller side; master: the writer/reader/RAM environment side.
interface fmap_pingpong_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_en;
    logic                  rd_avail;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic [ADDR_WIDTH:0]   ram_addr_a;
    logic [DATA_WIDTH-1:0] ram_data_a;
    logic                  ram_wren_a;
    logic [ADDR_WIDTH:0]   ram_addr_b;
    logic                  ram_rden_b;
    logic [DATA_WIDTH-1:0] ram_q_b;
    logic                  err;

    modport slave (
        input  wr_en, wr_data, rd_en, ram_q_b,
        output wr_ready, rd_avail, rd_valid, rd_data, rd_last,
               ram_addr_a, ram_data_a, ram_wren_a, ram_addr_b, ram_rden_b, err
    );

    modport master (
        output wr_en, wr_data, rd_en, ram_q_b,
        input  wr_ready, rd_avail, rd_valid, rd_data, rd_last,
               ram_addr_a, ram_data_a, ram_wren_a, ram_addr_b, ram_rden_b, err
    );
endinterface

// File: rtl/fmap_pingpong_ctrl.sv
// Ping-pong bank scheduler for the pooling-stage feature-map RAM.
// One dual-port RAM, split into two banks by the address MSB; the writer fills
// one bank on port A while the reader drains the other on port B.
// Optional feature: define PP_ERR_FLAG_EN to build the sticky protocol-error flag.
module fmap_pingpong_ctrl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned FRAME_WORDS = 196
) (
    input  logic             clock,
    input  logic             reset,
    fmap_pingpong_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    bank_state_e           bank_q [2];
    bank_state_e           bank_d [2];
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;

    logic                  wr_ready_c;
    logic                  rd_avail_c;
    logic                  wr_acc_c;
    logic                  rd_acc_c;

    logic [ADDR_WIDTH:0]   ram_addr_a_q;
    logic [DATA_WIDTH-1:0] ram_data_a_q;
    logic                  ram_wren_a_q;
    logic [ADDR_WIDTH:0]   ram_addr_b_q;
    logic                  ram_rden_b_q;
    logic                  last_p1_q;
    logic                  rd_valid_q;
    logic                  rd_last_q;

    // Handshake qualifiers straight from bank ownership
    assign wr_ready_c = (bank_q[wr_bank_q] == BANK_EMPTY) || (bank_q[wr_bank_q] == BANK_FILLING);
    assign rd_avail_c = (bank_q[rd_bank_q] == BANK_FULL)  || (bank_q[rd_bank_q] == BANK_DRAINING);
    assign wr_acc_c   = bus.wr_en && wr_ready_c;
    assign rd_acc_c   = bus.rd_en && rd_avail_c;

    // Bank state, pointers and word counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            bank_q    <= bank_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Next state; writer and reader always own different banks, so both may update at once
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;

        if (wr_acc_c) begin
            if (wr_cnt_q == LAST_CNT) begin
                bank_d[wr_bank_q] = BANK_FULL;
                wr_cnt_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                bank_d[wr_bank_q] = BANK_FILLING;
                wr_cnt_d          = wr_cnt_q + CNT_ONE;
            end
        end

        if (rd_acc_c) begin
            if (rd_cnt_q == LAST_CNT) begin
                bank_d[rd_bank_q] = BANK_EMPTY;
                rd_cnt_d          = '0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                bank_d[rd_bank_q] = BANK_DRAINING;
                rd_cnt_d          = rd_cnt_q + CNT_ONE;
            end
        end
    end

    // RAM port strobes one cycle after acceptance, read-data qualifiers one cycle later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_addr_a_q <= '0;
            ram_data_a_q <= '0;
            ram_wren_a_q <= 1'b0;
            ram_addr_b_q <= '0;
            ram_rden_b_q <= 1'b0;
            last_p1_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            ram_wren_a_q <= wr_acc_c;
            ram_rden_b_q <= rd_acc_c;
            last_p1_q    <= rd_acc_c && (rd_cnt_q == LAST_CNT);
            rd_valid_q   <= ram_rden_b_q;
            rd_last_q    <= last_p1_q;
            if (wr_acc_c) begin
                ram_addr_a_q <= {wr_bank_q, wr_cnt_q};
                ram_data_a_q <= bus.wr_data;
            end
            if (rd_acc_c) begin
                ram_addr_b_q <= {rd_bank_q, rd_cnt_q};
            end
        end
    end

    assign bus.wr_ready   = wr_ready_c;
    assign bus.rd_avail   = rd_avail_c;
    assign bus.ram_addr_a = ram_addr_a_q;
    assign bus.ram_data_a = ram_data_a_q;
    assign bus.ram_wren_a = ram_wren_a_q;
    assign bus.ram_addr_b = ram_addr_b_q;
    assign bus.ram_rden_b = ram_rden_b_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_last    = rd_last_q;
    assign bus.rd_data    = bus.ram_q_b;

`ifdef PP_ERR_FLAG_EN
    logic err_q;

    // Sticky flag for a request made while the addressed bank cannot serve it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((bus.wr_en && !wr_ready_c) || (bus.rd_en && !rd_avail_c)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: doc/fmap_pingpong_ctrl.md
Name: fmap_pingpong_ctrl

Overview:
Ping-pong scheduler for the pooling-stage feature-map RAM, implemented as one dual-port RAM split into two banks by the address MSB. The conv/pool writer fills one bank through port A while the next-layer reader drains the other bank through port B. Banks swap automatically on frame completion. The block generates all RAM addresses and enables, so neither side tracks bank ownership.

Parameters:
DATA_WIDTH, 16, width of one feature-map word
ADDR_WIDTH, 10, per-bank word-address width; RAM address is ADDR_WIDTH+1 bits
FRAME_WORDS, 196, words per frame (one bank's fill), 1 <= FRAME_WORDS <= 2**ADDR_WIDTH

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
wr_en  in  1  writer offers wr_data this cycle
wr_data  in  DATA_WIDTH  word to store
wr_ready  out  1  a bank is writable; the write is accepted when wr_en && wr_ready
rd_en  in  1  reader requests the next word
rd_avail  out  1  the read bank holds unread data; the read is accepted when rd_en && rd_avail
rd_valid  out  1  rd_data valid (no backpressure)
rd_data  out  DATA_WIDTH  word read, driven directly from ram_q_b
rd_last  out  1  qualifies the last word of a frame, coincident with rd_valid
ram_addr_a  out  ADDR_WIDTH+1  write address {wr_bank, wr_cnt}
ram_data_a  out  DATA_WIDTH  write data
ram_wren_a  out  1  write enable
ram_addr_b  out  ADDR_WIDTH+1  read address {rd_bank, rd_cnt}
ram_rden_b  out  1  read enable
ram_q_b  in  DATA_WIDTH  RAM read data, 1-cycle latency after ram_rden_b
err  out  1  sticky protocol error (optional feature)

Behaviour:
- Reset (asynchronous, active-high) clears everything. Both banks go to EMPTY. wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0. All outputs go to 0, except wr_ready, which is 1 (it is combinational from bank state). Reset mid-frame discards partial and full frames; no RAM access follows.
- Each bank has a 2-bit state: EMPTY, FILLING, FULL, DRAINING.
- wr_ready = state[wr_bank] is EMPTY or FILLING (combinational).
- rd_avail = state[rd_bank] is FULL or DRAINING (combinational).
- Accepted write:
  - EMPTY goes to FILLING.
  - wr_cnt increments.
  - When wr_cnt==FRAME_WORDS-1: the bank goes to FULL, wr_cnt wraps to 0, and wr_bank toggles.
  - If FRAME_WORDS==1, EMPTY goes directly to FULL.
- Accepted read:
  - FULL goes to DRAINING.
  - rd_cnt increments.
  - When rd_cnt==FRAME_WORDS-1: the bank goes to EMPTY, rd_cnt wraps to 0, and rd_bank toggles.
- Write latency: ram_wren_a, ram_addr_a and ram_data_a are registered and assert exactly 1 cycle after acceptance; ram_wren_a is low otherwise.
- Read latency:
  - ram_rden_b and ram_addr_b are registered and assert 1 cycle after acceptance.
  - rd_valid asserts 2 cycles after acceptance; rd_last rides with rd_valid for word FRAME_WORDS-1.
  - Back-to-back accepted reads give back-to-back rd_valid.
- A bank that becomes FULL in cycle N is readable from cycle N+1 (rd_avail=1). The final RAM write lands at N+1 and the earliest RAM read at N+2, so there is no read-before-write hazard.
- Both banks FULL or DRAINING: wr_ready=0. wr_en is ignored, with no state change and no RAM write.
- Both banks EMPTY: rd_avail=0. rd_en is ignored.
- Simultaneous accepted write and read (always different banks):
  - Both update in the same cycle.
  - A write that completes the frame on one bank and a read that completes the frame on the other bank, in the same cycle, both swap pointers.
- Bank states never allow writer and reader on the same bank.

Optional Feature:
Macro PP_ERR_FLAG_EN.
- Defined: err sets 1 cycle after wr_en && !wr_ready, or after rd_en && !rd_avail. It stays set until reset.
- Undefined: err is tied to 0 and no error logic is built.

Test Plan:
- FRAME_WORDS=4, reset then 4 writes (data 0x11..0x14) → ram_wren_a at cycles 1-4 with addresses 0x000..0x003. Bank0 goes FULL, wr_bank=1, rd_avail=1 the cycle after the 4th accept.
- Read 4 words with continuous rd_en → ram_addr_b 0x000..0x003; rd_valid 2 cycles after each accept; rd_data 0x11..0x14; rd_last only on 0x14. Then rd_avail=0 and rd_bank=1.
- Write 8 words with no reads → after the 8th accept wr_ready=0. The 9th wr_en gives no ram_wren_a, and err=1 if PP_ERR_FLAG_EN.
- Concurrent operation: write bank1 while draining bank0, with both frames completing in the same cycle → wr_bank=0, rd_bank=1, bank0 FILLING-able, bank1 FULL. No lost or duplicated words over 3 frames.
- Assert reset after 2 of 4 writes → outputs cleared, rd_avail=0. A fresh 4-word frame restarts at address 0x000.
- rd_en on an empty buffer → no ram_rden_b and no rd_valid. err=1 with PP_ERR_FLAG_EN; err stays 0 without it.
